bus_regbank: RTL and testbench
==============================

Name: bus_regbank

Overview:
Parametrised register-bank slave on the PS-to-PL 16-bit strobe bus (baddr/bwrdata/brddata/bwr/bstrobe). It replaces the ad-hoc single-purpose LED decode with a set of features:
- ID word and R/W control registers.
- Read-only status words and a sticky event register.
- 2*DW-bit timestamp with atomic high-word snapshot.
- LED driver.
Read data is OR-able with other slaves, so several instances can share one bus.

Parameters:
AW, 16, bus address width
DW, 16, bus data width
BASE, 16'h0000, block base address; must be 64-aligned
NREG, 4, number of R/W control registers (2..16)
NSTAT, 2, number of read-only status words (0..16)
NEVT, 8, number of event inputs (1..DW)
NLED, 8, number of LED outputs (1..DW)
ID_VALUE, 16'hB0A1, constant returned at offset 0x00

Ports:
clk  in  1  bus clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
baddr  in  AW  bus address
bwrdata  in  DW  bus write data
bwr  in  1  write qualifier, sampled with bstrobe
bstrobe  in  1  one-cycle access strobe
brddata  out  DW  registered read data; 0 when not selected
back  out  1  one-cycle acknowledge for a populated-address hit
stat_in  in  NSTAT*DW  status words, already in clk domain
evt_in  in  NEVT  event levels, already in clk domain
ctrl_out  out  NREG*DW  R/W register contents
led  out  NLED  LED drive

Behaviour:
- Hit: bstrobe=1 and baddr[AW-1:6]==BASE[AW-1:6]. Offset = baddr[5:0].
- Map:
  - 0x00 ID (RO)
  - 0x01 EVT (W1C)
  - 0x02 TS_LO (read snapshots high word; any write clears the counter)
  - 0x03 TS_HI (RO shadow)
  - 0x10+i CTRL[i], i<NREG (RW)
  - 0x20+j STAT[j], j<NSTAT (RO)
- Unpopulated offsets: no ack, read 0, write ignored. Writes to RO offsets are ignored but still acknowledged.
- Write: a hit with bwr=1 updates the target on that edge; the new value is visible on ctrl_out the next cycle.
- Read: a hit with bwr=0 registers the target value into brddata at that edge. brddata is valid the following cycle and held until the next strobe.
- Any strobe that is a miss, or is a write, loads brddata=0.
- back: pulses 1 the cycle after any populated hit (read or write).
- Latency: one cycle. Back-to-back strobes every cycle are legal.
- STAT read returns stat_in sampled at the strobe edge.
- EVT:
  - evt_prev is a register.
  - Bit k sets when evt_in[k]=1 and evt_prev[k]=0.
  - Writing 1 clears bit k. If set and clear occur on the same edge, set wins.
  - Bits >= NEVT read 0.
- Timestamp:
  - 2*DW-bit counter, +1 every clk, wraps from all-ones to 0.
  - Reading TS_LO returns counter[DW-1:0] and, on the same edge, loads ts_shadow<=counter[2*DW-1:DW].
  - Reading TS_HI returns ts_shadow, so the LO-then-HI pair is coherent across a carry.
  - Writing TS_LO forces counter=0 on that edge; counter is 1 the next edge.
- LED: led = CTRL[0][NLED-1:0].
- Reset (async assert, sync release by the system):
  - brddata=0, back=0, CTRL all 0, EVT=0, evt_prev=0, counter=0, ts_shadow=0, led=0.
  - Because evt_prev resets to 0, an evt_in held high through reset sets its EVT bit on the first edge after release.
- Reset mid-access: the access is lost, with no ack.

Optional Feature:
Macro BUS_REGBANK_LED_PWM_EN.
- Defined:
  - 8-bit free-running pwm_cnt (reset 0).
  - led[k] = CTRL[0][k] & (pwm_cnt < CTRL[1][7:0]).
  - Duty 0 gives off; 255 gives on 255/256 of the time.
  - Requires NREG>=2.
- Undefined: no PWM counter; led = CTRL[0][NLED-1:0] directly. CTRL[1] is a plain register.

Decomposition:
- Package bus_regbank_pkg: offset constants (OFF_ID, OFF_EVT, OFF_TS_LO, OFF_TS_HI, OFF_CTRL, OFF_STAT), block span 64, default ID_VALUE.
- One natural sub-module: regbank_tstamp. It holds the counter, clear, and snapshot shadow, with inputs clk, rst_n, clr, snap and outputs lo, hi_shadow.

Test Plan:
1. Reset, then read BASE+0x00 -> brddata=16'hB0A1, back=1 one cycle later. Read BASE+0x3F -> brddata=0, back=0.
2. Write 16'h00A5 to BASE+0x10 -> ctrl_out[15:0]=16'h00A5 and led=8'hA5 next cycle. Read back -> 16'h00A5. Write to BASE+0x40 (miss) -> no change, no ack.
3. Pulse evt_in[3] -> EVT reads 16'h0008. Write 16'h0008 on the same edge as a new evt_in[3] rise -> still 16'h0008. A clearing write with no new edge -> 16'h0000.
4. Write TS_LO. Wait until counter=32'h0000_FFFF, read TS_LO -> 16'hFFFF. Then read TS_HI -> 16'h0000, even though the live high word is now 1.
5. Issue read strobes on consecutive cycles to STAT0 and STAT1 with stat_in={16'h1234,16'h5678} -> brddata 16'h5678 then 16'h1234, back high both cycles.
6. With BUS_REGBANK_LED_PWM_EN defined: CTRL0=8'hFF, CTRL1=8'h40 -> led high 64 of every 256 cycles. Assert rst_n=0 mid-period -> led=0 immediately.

Source files
------------

// File: rtl/bus_regbank_pkg.sv
// rtl/bus_regbank_pkg.sv - offset map and defaults shared by the register bank
package bus_regbank_pkg;
    localparam logic [5:0]  OFF_ID       = 6'h00;
    localparam logic [5:0]  OFF_EVT      = 6'h01;
    localparam logic [5:0]  OFF_TS_LO    = 6'h02;
    localparam logic [5:0]  OFF_TS_HI    = 6'h03;
    localparam logic [5:0]  OFF_CTRL     = 6'h10;
    localparam logic [5:0]  OFF_STAT     = 6'h20;
    localparam int          BLOCK_SPAN   = 64;
    localparam logic [15:0] DEF_ID_VALUE = 16'hB0A1;
endpackage

// File: rtl/bus_regbank_if.sv
// rtl/bus_regbank_if.sv - strobe bus between the PS master and PL register slaves
interface bus_regbank_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [AW-1:0] baddr;
    logic [DW-1:0] bwrdata;
    logic          bwr;
    logic          bstrobe;
    logic [DW-1:0] brddata;
    logic          back;

    modport master (output baddr, bwrdata, bwr, bstrobe, input brddata, back);
    modport slave  (input baddr, bwrdata, bwr, bstrobe, output brddata, back);
endinterface

// File: rtl/bus_regbank_tstamp.sv
// rtl/bus_regbank_tstamp.sv - 2*DW-bit free-running timestamp with high-word snapshot
module regbank_tstamp #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          snap,
    output logic [DW-1:0] lo,
    output logic [DW-1:0] hi_shadow
);
    logic [2*DW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            hi_shadow <= '0;
        end else begin
            cnt <= clr ? '0 : cnt + (2*DW)'(1);
            // Shadow holds the high word that matches the low word read on this edge
            if (snap) hi_shadow <= cnt[2*DW-1:DW];
        end
    end

    assign lo = cnt[DW-1:0];
endmodule

// File: rtl/bus_regbank.sv
// rtl/bus_regbank.sv - register-bank slave on the strobe bus (ID, EVT, timestamp, CTRL, STAT, LED)
// Optional LED PWM via BUS_REGBANK_LED_PWM_EN (duty in CTRL[1][7:0]).
module bus_regbank
    import bus_regbank_pkg::*;
#(
    parameter int            AW       = 16,
    parameter int            DW       = 16,
    parameter logic [AW-1:0] BASE     = '0,
    parameter int            NREG     = 4,
    parameter int            NSTAT    = 2,
    parameter int            NEVT     = 8,
    parameter int            NLED     = 8,
    parameter logic [DW-1:0] ID_VALUE = DW'(DEF_ID_VALUE)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    bus_regbank_if.slave                           bus,
    input  logic [(NSTAT > 0 ? NSTAT : 1)*DW-1:0]  stat_in,
    input  logic [NEVT-1:0]                        evt_in,
    output logic [NREG*DW-1:0]                     ctrl_out,
    output logic [NLED-1:0]                        led
);
    logic [DW-1:0]   ctrl_q [NREG];
    logic [NEVT-1:0] evt_q;
    logic [NEVT-1:0] evt_prev;
    logic [NEVT-1:0] evt_clr;
    logic [DW-1:0]   rd_q;
    logic            ack_q;
    logic [DW-1:0]   rd_val;
    logic            populated;
    logic [DW-1:0]   ts_lo;
    logic [DW-1:0]   ts_hi;
    logic            hit;
    logic            wr_hit;
    logic [5:0]      off;

    assign hit    = bus.bstrobe && (bus.baddr[AW-1:6] == BASE[AW-1:6]);
    assign wr_hit = hit && bus.bwr;
    assign off    = bus.baddr[5:0];

    always_comb begin
        rd_val    = '0;
        populated = 1'b0;
        case (off)
            OFF_ID:    begin populated = 1'b1; rd_val = ID_VALUE; end
            OFF_EVT:   begin populated = 1'b1; rd_val[NEVT-1:0] = evt_q; end
            OFF_TS_LO: begin populated = 1'b1; rd_val = ts_lo; end
            OFF_TS_HI: begin populated = 1'b1; rd_val = ts_hi; end
            default:   ;
        endcase
        for (int i = 0; i < NREG; i++) begin
            if (off == OFF_CTRL + 6'(i)) begin
                populated = 1'b1;
                rd_val    = ctrl_q[i];
            end
        end
        for (int j = 0; j < NSTAT; j++) begin
            if (off == OFF_STAT + 6'(j)) begin
                populated = 1'b1;
                rd_val    = stat_in[j*DW +: DW];
            end
        end
    end

    assign evt_clr = (wr_hit && off == OFF_EVT) ? bus.bwrdata[NEVT-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '{default: '0};
            evt_q    <= '0;
            evt_prev <= '0;
            rd_q     <= '0;
            ack_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_hit && off == OFF_CTRL + 6'(i)) ctrl_q[i] <= bus.bwrdata;
            end
            // A new rising edge outranks a W1C landing on the same cycle
            evt_q    <= (evt_q & ~evt_clr) | (evt_in & ~evt_prev);
            evt_prev <= evt_in;
            if (bus.bstrobe) rd_q <= (hit && !bus.bwr && populated) ? rd_val : '0;
            ack_q <= hit && populated;
        end
    end

    assign bus.brddata = rd_q;
    assign bus.back    = ack_q;

    regbank_tstamp #(.DW(DW)) u_tstamp (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (wr_hit && off == OFF_TS_LO),
        .snap      (hit && !bus.bwr && off == OFF_TS_LO),
        .lo        (ts_lo),
        .hi_shadow (ts_hi)
    );

    always_comb begin
        ctrl_out = '0;
        for (int i = 0; i < NREG; i++) ctrl_out[i*DW +: DW] = ctrl_q[i];
    end

`ifdef BUS_REGBANK_LED_PWM_EN
    logic [7:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 8'd1;
    end

    assign led = ctrl_q[0][NLED-1:0] & {NLED{pwm_cnt < ctrl_q[1][7:0]}};
`else
    assign led = ctrl_q[0][NLED-1:0];
`endif
endmodule

// File: tb/tb_bus_regbank.sv
// tb/tb_bus_regbank.sv - randomized self-checking bench for bus_regbank
module tb_bus_regbank;
    localparam int          AW    = 16;
    localparam int          DW    = 16;
    localparam int          NREG  = 4;
    localparam int          NSTAT = 2;
    localparam int          NEVT  = 8;
    localparam int          NLED  = 8;
    localparam logic [15:0] BASE  = 16'h0140;
    localparam logic [15:0] ID    = 16'hB0A1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NSTAT*DW-1:0]   stat_in;
    logic [NEVT-1:0]       evt_in;
    logic [NREG*DW-1:0]    ctrl_out;
    logic [NLED-1:0]       led;

    bus_regbank_if #(.AW(AW), .DW(DW)) bus ();

    bus_regbank #(
        .AW(AW), .DW(DW), .BASE(BASE), .NREG(NREG), .NSTAT(NSTAT),
        .NEVT(NEVT), .NLED(NLED), .ID_VALUE(ID)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .stat_in(stat_in),
        .evt_in(evt_in), .ctrl_out(ctrl_out), .led(led)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] ctrl_m [NREG];
    logic [7:0]  evt_m;
    logic [7:0]  evt_prev_m;
    logic [15:0] shadow_m;
    int unsigned n_clr;
    int unsigned n_rst;
    logic [15:0] exp_rd;
    logic        exp_ack;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) ctrl_m[i] = '0;
        evt_m = '0; evt_prev_m = '0; shadow_m = '0; exp_rd = '0; exp_ack = 1'b0;
        n_clr = cyc; n_rst = cyc;
    endtask

    function automatic logic [NREG*DW-1:0] exp_ctrl();
        logic [NREG*DW-1:0] v;
        for (int i = 0; i < NREG; i++) v[i*DW +: DW] = ctrl_m[i];
        return v;
    endfunction

    function automatic logic [NLED-1:0] exp_led();
`ifdef BUS_REGBANK_LED_PWM_EN
        int unsigned pwm;
        pwm = (cyc - n_rst) % 256;
        return (pwm < int'(ctrl_m[1][7:0])) ? ctrl_m[0][NLED-1:0] : '0;
`else
        return ctrl_m[0][NLED-1:0];
`endif
    endfunction

    // Drive one bus cycle at a negedge, predict its effects, advance to the next negedge
    task automatic step(input logic stb, input logic [15:0] addr, input logic wr, input logic [15:0] data);
        logic [31:0] ts;
        logic        hit;
        logic        pop;
        logic [15:0] val;
        int          o;
        bus.bstrobe = stb; bus.baddr = addr; bus.bwr = wr; bus.bwrdata = data;
        ts  = 32'(cyc - n_clr);
        hit = stb && (addr[15:6] == BASE[15:6]);
        o   = int'(addr[5:0]);
        pop = 1'b1;
        val = '0;
        if (o == 0)                         val = ID;
        else if (o == 1)                    val = {8'h00, evt_m};
        else if (o == 2)                    val = ts[15:0];
        else if (o == 3)                    val = shadow_m;
        else if (o >= 16 && o < 16 + NREG)  val = ctrl_m[o-16];
        else if (o >= 32 && o < 32 + NSTAT) val = stat_in[(o-32)*16 +: 16];
        else                                pop = 1'b0;
        if (stb) exp_rd = (hit && !wr && pop) ? val : 16'h0000;
        exp_ack = hit && pop;
        if (hit && wr && o >= 16 && o < 16 + NREG) ctrl_m[o-16] = data;
        if (hit && !wr && o == 2) shadow_m = ts[31:16];
        if (hit && wr && o == 2) n_clr = cyc + 1;
        evt_m = (evt_m & ~((hit && wr && o == 1) ? data[7:0] : 8'h00)) | (evt_in & ~evt_prev_m);
        evt_prev_m = evt_in;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.bstrobe = 0; bus.baddr = 0; bus.bwr = 0; bus.bwrdata = 0;
        evt_in = '0; stat_in = '0;
        repeat (3) @(negedge clk);
        n_chk++; if (bus.brddata !== 16'h0) begin n_fail++; $display("FAIL reset_brddata got %h want 0000", bus.brddata); end
        n_chk++; if (bus.back !== 1'b0) begin n_fail++; $display("FAIL reset_back got %b want 0", bus.back); end
        n_chk++; if (ctrl_out !== '0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", ctrl_out); end
        n_chk++; if (led !== '0) begin n_fail++; $display("FAIL reset_led got %h want 00", led); end
        rst_n = 1'b1;
        model_reset();
        step(1, BASE + 16'h00, 0, 0);
        n_chk++; if (bus.brddata !== 16'hB0A1) begin n_fail++; $display("FAIL id_read got %h want b0a1", bus.brddata); end
        n_chk++; if (bus.back !== 1'b1) begin n_fail++; $display("FAIL id_ack got %b want 1", bus.back); end
        step(1, BASE + 16'h3F, 0, 0);
        n_chk++; if (bus.brddata !== 16'h0) begin n_fail++; $display("FAIL unpop_read got %h want 0000", bus.brddata); end
        n_chk++; if (bus.back !== 1'b0) begin n_fail++; $display("FAIL unpop_ack got %b want 0", bus.back); end
    endtask

    task automatic test_ctrl();
        step(1, BASE + 16'h10, 1, 16'h00A5);
        n_chk++; if (ctrl_out[15:0] !== 16'h00A5) begin n_fail++; $display("FAIL ctrl_write got %h want 00a5", ctrl_out[15:0]); end
        n_chk++; if (led !== exp_led()) begin n_fail++; $display("FAIL ctrl_led got %h want %h", led, exp_led()); end
        n_chk++; if (bus.back !== 1'b1 || bus.brddata !== 16'h0) begin n_fail++; $display("FAIL ctrl_wr_resp got ack=%b rd=%h want ack=1 rd=0000", bus.back, bus.brddata); end
        step(1, BASE + 16'h10, 0, 0);
        n_chk++; if (bus.brddata !== 16'h00A5) begin n_fail++; $display("FAIL ctrl_readback got %h want 00a5", bus.brddata); end
        step(1, BASE + 16'h40 + 16'h10, 1, 16'hFFFF);
        n_chk++; if (ctrl_out !== exp_ctrl() || ctrl_out[15:0] !== 16'h00A5) begin n_fail++; $display("FAIL miss_write got %h want %h", ctrl_out, exp_ctrl()); end
        n_chk++; if (bus.back !== 1'b0) begin n_fail++; $display("FAIL miss_ack got %b want 0", bus.back); end
    endtask

    task automatic test_evt();
        evt_in = 8'h08; step(0, 0, 0, 0);
        evt_in = 8'h00; step(1, BASE + 16'h01, 0, 0);
        n_chk++; if (bus.brddata !== 16'h0008) begin n_fail++; $display("FAIL evt_set got %h want 0008", bus.brddata); end
        evt_in = 8'h08; step(1, BASE + 16'h01, 1, 16'h0008);
        evt_in = 8'h00; step(1, BASE + 16'h01, 0, 0);
        n_chk++; if (bus.brddata !== 16'h0008) begin n_fail++; $display("FAIL evt_set_wins got %h want 0008", bus.brddata); end
        step(1, BASE + 16'h01, 1, 16'h0008);
        step(1, BASE + 16'h01, 0, 0);
        n_chk++; if (bus.brddata !== 16'h0000) begin n_fail++; $display("FAIL evt_clear got %h want 0000", bus.brddata); end
    endtask

    task automatic test_tstamp();
        step(1, BASE + 16'h02, 1, 16'h1234);
        bus.bstrobe = 1'b0;
        for (int k = 0; k < 70000 && 32'(cyc - n_clr) != 32'h0000_FFFF; k++) @(negedge clk);
        n_chk++; if (32'(cyc - n_clr) !== 32'h0000_FFFF) begin n_fail++; $display("FAIL ts_wait got %h want 0000ffff", 32'(cyc - n_clr)); end
        step(1, BASE + 16'h02, 0, 0);
        n_chk++; if (bus.brddata !== 16'hFFFF) begin n_fail++; $display("FAIL ts_lo got %h want ffff", bus.brddata); end
        step(1, BASE + 16'h03, 0, 0);
        n_chk++; if (bus.brddata !== 16'h0000) begin n_fail++; $display("FAIL ts_hi_coherent got %h want 0000", bus.brddata); end
        step(1, BASE + 16'h02, 0, 0);
        n_chk++; if (bus.brddata !== exp_rd) begin n_fail++; $display("FAIL ts_lo2 got %h want %h", bus.brddata, exp_rd); end
        step(1, BASE + 16'h03, 0, 0);
        n_chk++; if (bus.brddata !== 16'h0001) begin n_fail++; $display("FAIL ts_hi2 got %h want 0001", bus.brddata); end
    endtask

    task automatic test_back_to_back();
        stat_in = {16'h1234, 16'h5678};
        step(1, BASE + 16'h20, 0, 0);
        n_chk++; if (bus.brddata !== 16'h5678 || bus.back !== 1'b1) begin n_fail++; $display("FAIL stat0 got rd=%h ack=%b want 5678/1", bus.brddata, bus.back); end
        step(1, BASE + 16'h21, 0, 0);
        n_chk++; if (bus.brddata !== 16'h1234 || bus.back !== 1'b1) begin n_fail++; $display("FAIL stat1 got rd=%h ack=%b want 1234/1", bus.brddata, bus.back); end
        step(0, BASE + 16'h21, 0, 0);
        n_chk++; if (bus.brddata !== 16'h1234 || bus.back !== 1'b0) begin n_fail++; $display("FAIL rd_hold got rd=%h ack=%b want 1234/0", bus.brddata, bus.back); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [15:0] a;
            logic [5:0]  o;
            int          pick;
            pick = $urandom_range(0, 9);
            case (pick)
                0, 1, 2, 3: o = 6'(pick);
                4, 5:       o = 6'(16 + $urandom_range(0, 5));
                6, 7:       o = 6'(32 + $urandom_range(0, 2));
                default:    o = 6'($urandom_range(0, 63));
            endcase
            a = BASE | {10'h0, o};
            if ($urandom_range(0, 7) == 0) a = a ^ (16'h0040 << $urandom_range(0, 9));
            evt_in  = 8'($urandom);
            stat_in = 32'($urandom);
            step(1'($urandom_range(0, 5) != 0), a, 1'($urandom_range(0, 1)), 16'($urandom));
            n_chk++; if (bus.brddata !== exp_rd) begin n_fail++; $display("FAIL rnd_rd[%0d] got %h want %h", n, bus.brddata, exp_rd); end
            n_chk++; if (bus.back !== exp_ack) begin n_fail++; $display("FAIL rnd_ack[%0d] got %b want %b", n, bus.back, exp_ack); end
            n_chk++; if (ctrl_out !== exp_ctrl()) begin n_fail++; $display("FAIL rnd_ctrl[%0d] got %h want %h", n, ctrl_out, exp_ctrl()); end
            n_chk++; if (led !== exp_led()) begin n_fail++; $display("FAIL rnd_led[%0d] got %h want %h", n, led, exp_led()); end
        end
        evt_in = '0;
        step(1, BASE + 16'h01, 1, 16'hFFFF);
        step(1, BASE + 16'h01, 0, 0);
        n_chk++; if (bus.brddata !== exp_rd) begin n_fail++; $display("FAIL evt_drain got %h want %h", bus.brddata, exp_rd); end
    endtask

`ifdef BUS_REGBANK_LED_PWM_EN
    task automatic test_pwm();
        int on_cnt;
        step(1, BASE + 16'h10, 1, 16'h00FF);
        step(1, BASE + 16'h11, 1, 16'h0040);
        bus.bstrobe = 1'b0;
        on_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            if (led === 8'hFF) on_cnt++;
            @(negedge clk);
        end
        n_chk++; if (on_cnt !== 64) begin n_fail++; $display("FAIL pwm_duty got %0d want 64", on_cnt); end
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (led !== '0 || ctrl_out !== '0) begin n_fail++; $display("FAIL pwm_reset got led=%h ctrl=%h want 0", led, ctrl_out); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_ctrl();
        test_evt();
        test_tstamp();
        test_back_to_back();
        test_random();
`ifdef BUS_REGBANK_LED_PWM_EN
        test_pwm();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
